// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot iteration engine.
//   DATA_W / FRAC_BITS : signed Q4.28 fixed-point format of c and z
//   fixed_t            : one fixed-point component
//   ESCAPE_R2          : |z|^2 escape threshold (4.0) in the Q8.56 magnitude format
//   TWO_FX             : 2.0 in Q4.28, the radius for the early-escape shortcut
//   state_t            : engine FSM states
package mandel_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned FRAC_BITS = 28;

  typedef logic signed [DATA_W-1:0] fixed_t;

  localparam logic signed [2*DATA_W:0] ESCAPE_R2 = (2*DATA_W+1)'(4) << (2*FRAC_BITS);
  localparam fixed_t                   TWO_FX    = fixed_t'(2) << FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mandel_step.sv
// One Mandelbrot iteration step, purely combinational.
//   z_re, z_im     : current z (signed fixed point)
//   c_re, c_im     : point being iterated
//   z_re_next      : trunc(z_re^2 - z_im^2) + c_re
//   z_im_next      : trunc(2*z_re*z_im) + c_im
//   escape         : z_re^2 + z_im^2 >= 4.0 at full precision
// All multipliers live here so the step can be pipelined without touching the FSM.
module mandel_step
  import mandel_pkg::*;
#(
  parameter int unsigned DATA_W    = mandel_pkg::DATA_W,
  parameter int unsigned FRAC_BITS = mandel_pkg::FRAC_BITS
) (
  input  logic signed [DATA_W-1:0] z_re,
  input  logic signed [DATA_W-1:0] z_im,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_im,
  output logic signed [DATA_W-1:0] z_re_next,
  output logic signed [DATA_W-1:0] z_im_next,
  output logic                     escape
);

  localparam logic signed [2*DATA_W:0] ESC_R2 = (2*DATA_W+1)'(4) << (2*FRAC_BITS);

  logic signed [2*DATA_W-1:0] p_rr;
  logic signed [2*DATA_W-1:0] p_ii;
  logic signed [2*DATA_W-1:0] p_ri;
  logic signed [2*DATA_W:0]   mag2;

  assign p_rr = z_re * z_re;
  assign p_ii = z_im * z_im;
  assign p_ri = z_re * z_im;

  assign mag2   = {p_rr[2*DATA_W-1], p_rr} + {p_ii[2*DATA_W-1], p_ii};
  assign escape = (mag2 >= ESC_R2);

  // Arithmetic shift then narrow == taking bits [FRAC_BITS+DATA_W-1:FRAC_BITS];
  // shifting the cross product by one less bit applies the factor of two for free.
  assign z_re_next = DATA_W'((p_rr - p_ii) >>> FRAC_BITS) + c_re;
  assign z_im_next = DATA_W'(p_ri >>> (FRAC_BITS - 1)) + c_im;

endmodule

// File: rtl/mandel_iter.sv
// Mandelbrot escape-time iteration engine.
// Accepts one point c per valid/ready handshake, iterates z <= z^2 + c from
// z = 0 at one iteration per clock and returns the escape index with the
// point's pixel tag.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready high only when idle)
//   in_c_re, in_c_im  : point c, signed Q4.28
//   in_tag            : opaque pixel tag carried to the output
//   max_iter          : iteration limit, sampled on accept
//   out_valid/out_ready : result handshake, outputs held while stalled
//   out_iter_count    : escape index, or max_iter if never escaped
//   out_escaped       : 1 = escaped, 0 = limit reached
//   out_tag           : tag of the point
module mandel_iter
  import mandel_pkg::*;
#(
  parameter int unsigned DATA_W    = mandel_pkg::DATA_W,
  parameter int unsigned FRAC_BITS = mandel_pkg::FRAC_BITS,
  parameter int unsigned ITER_W    = 16,
  parameter int unsigned TAG_W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_c_re,
  input  logic signed [DATA_W-1:0] in_c_im,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [ITER_W-1:0]        max_iter,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ITER_W-1:0]        out_iter_count,
  output logic                     out_escaped,
  output logic [TAG_W-1:0]         out_tag
);

  localparam logic signed [DATA_W-1:0] POS_TWO = DATA_W'(2) << FRAC_BITS;
  localparam logic signed [DATA_W-1:0] NEG_TWO = -POS_TWO;

  state_t                   state;
  logic signed [DATA_W-1:0] c_re;
  logic signed [DATA_W-1:0] c_im;
  logic signed [DATA_W-1:0] z_re;
  logic signed [DATA_W-1:0] z_im;
  logic [ITER_W-1:0]        n;
  logic [ITER_W-1:0]        max_r;

  logic signed [DATA_W-1:0] z_re_next;
  logic signed [DATA_W-1:0] z_im_next;
  logic                     escape;
  logic                     shortcut;

  // Points outside the |c| < 2 box escape at index 1; rejecting them up front
  // also bounds |z| < 8 during iteration, so the step needs no saturation.
  assign shortcut = (in_c_re >= POS_TWO) || (in_c_re <= NEG_TWO) ||
                    (in_c_im >= POS_TWO) || (in_c_im <= NEG_TWO);

  mandel_step #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_step (
    .z_re      (z_re),
    .z_im      (z_im),
    .c_re      (c_re),
    .c_im      (c_im),
    .z_re_next (z_re_next),
    .z_im_next (z_im_next),
    .escape    (escape)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_iter_count <= '0;
      out_escaped    <= 1'b0;
      out_tag        <= '0;
      c_re           <= '0;
      c_im           <= '0;
      z_re           <= '0;
      z_im           <= '0;
      n              <= '0;
      max_r          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_re     <= in_c_re;
            c_im     <= in_c_im;
            out_tag  <= in_tag;
            max_r    <= max_iter;
            z_re     <= '0;
            z_im     <= '0;
            n        <= '0;
            in_ready <= 1'b0;
            if (shortcut) begin
              state          <= DONE;
              out_valid      <= 1'b1;
              out_iter_count <= ITER_W'(1);
              out_escaped    <= 1'b1;
            end else begin
              state <= ITER;
            end
          end
        end

        ITER: begin
          if (escape) begin
            state          <= DONE;
            out_valid      <= 1'b1;
            out_iter_count <= n;
            out_escaped    <= 1'b1;
          end else if (n == max_r) begin
            state          <= DONE;
            out_valid      <= 1'b1;
            out_iter_count <= max_r;
            out_escaped    <= 1'b0;
          end else begin
            z_re <= z_re_next;
            z_im <= z_im_next;
            n    <= n + ITER_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mandel_iter.md
Name: mandel_iter

Overview:
- Iteration engine directly downstream of the screen mapper.
- Accepts one complex point c = (c_re, c_im) per transaction in signed Q4.28 fixed point, iterates z(n+1) = z(n)^2 + c from z0 = 0, and returns the escape iteration count.
- One iteration per clock; valid/ready handshakes on both sides, so several instances can be farmed by a pixel dispatcher.
- An opaque pixel tag travels with each point for reordering downstream.

Parameters:
- DATA_W, 32: width of c and z components (signed).
- FRAC_BITS, 28: fractional bits of the fixed-point format.
- ITER_W, 16: width of max_iter and iter_count.
- TAG_W, 20: width of the sideband pixel tag ({y,x}).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_valid  in  1  point offered
- in_ready  out  1  engine can accept
- in_c_re  in  DATA_W  real part of c, signed Q4.28
- in_c_im  in  DATA_W  imaginary part of c, signed Q4.28
- in_tag  in  TAG_W  pixel tag
- max_iter  in  ITER_W  iteration limit, sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_iter_count  out  ITER_W  escape index n, or max_iter if never escaped
- out_escaped  out  1  1 = escaped, 0 = hit limit
- out_tag  out  TAG_W  tag of the accepted point

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, on port rst.
- Reset: state IDLE, in_ready=1, out_valid=0, out_iter_count=0, out_escaped=0, out_tag=0, z=0, n=0. Any in-flight point is discarded, including a point reset mid-ITER or mid-DONE.
- States: IDLE, ITER, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: on in_valid, capture c, tag and max_iter; set z=0, n=0.
  - Shortcut: if |c_re| >= 2.0 or |c_im| >= 2.0, go directly to DONE with count=1, escaped=1.
  - Otherwise go to ITER.
- ITER, each cycle, evaluated in this order:
  - mag2 = z_re^2 + z_im^2, computed at full precision (Q8.56, 2*DATA_W+1 bits).
  - If mag2 >= 4.0 (4 << 2*FRAC_BITS): DONE, count=n, escaped=1.
  - Else if n == max_iter: DONE, count=max_iter, escaped=0.
  - Else: z_re <= trunc(z_re^2 - z_im^2) + c_re; z_im <= trunc(2*z_re*z_im) + c_im; n <= n+1.
- Arithmetic:
  - Products are 2*DATA_W signed.
  - trunc takes bits [FRAC_BITS+DATA_W-1 : FRAC_BITS] (arithmetic truncation toward minus infinity).
  - The doubled cross product takes bits [FRAC_BITS+DATA_W-2 : FRAC_BITS-1].
  - The shortcut guarantees |z| < 8 before every update, so no overflow handling is needed.
- Latency from accept cycle T:
  - Escape at index n: out_valid at T+n+2.
  - Limit reached: out_valid at T+max_iter+2.
  - Shortcut: out_valid at T+1.
- max_iter=0: result count=0, escaped=0 at T+2 (z0=0 never escapes).
- DONE: outputs held stable while out_ready=0. On out_ready, go to IDLE; in_ready rises the following cycle (no same-cycle accept-on-drain).
- in_valid while not in_ready is ignored. Inputs need not stay stable after the accept cycle.

Decomposition:
- mandel_pkg holds:
  - DATA_W and FRAC_BITS constants.
  - fixed_t (logic signed [DATA_W-1:0]).
  - ESCAPE_R2 constant.
  - TWO_FX constant (2.0 in Q4.28).
  - state_t enum {IDLE, ITER, DONE}.
- Sub-module mandel_step: purely combinational (z_re, z_im, c_re, c_im) -> (z_re_next, z_im_next, escape). It holds all multipliers so it can be pipelined later without touching the FSM.

Test Plan:
- c=(0,0), max_iter=100 -> count=100, escaped=0, out_valid exactly 102 cycles after accept.
- c=(1.0=0x1000_0000, 0), max_iter=255 -> z1=1, z2=2, mag2=4.0 escapes: count=2, escaped=1, out_valid at T+4. Checks the >= boundary.
- c=(0.5=0x0800_0000, 0), max_iter=255 -> count=5, escaped=1.
- c=(-2.0=0xE000_0000, 0) -> shortcut: count=1, escaped=1, out_valid at T+1.
- c=(-1.0, 0), max_iter=50, tag=0xABCDE, out_ready held low 10 cycles after out_valid:
  - count=50, escaped=0, out_tag=0xABCDE.
  - Outputs stable and in_ready=0 throughout the hold.
  - in_ready=1 the cycle after the out_ready handshake.
- rst asserted mid-ITER of c=(0,0), max_iter=1000 -> next cycle in_ready=1, out_valid=0. The next point, c=(1.0,0), returns count=2 with no residue from the discarded point.
